// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
//
// Run/pause/clear controller for a 16-bit enable-chained counter. Three
// debounced push-button levels are turned into start, stop and clear
// commands by rising-edge detection. While running, the clock is divided
// into a one-cycle count-enable tick. Counting stops at a programmable
// terminal value, read back from the counter's output.
//
// Parameters
//   DIV     prescaler period in Clk cycles between En ticks (>= 2)
//
// Ports
//   Clk     in   1   system clock, rising edge
//   Clr     in   1   asynchronous active-low reset
//   Start   in   1   debounced level, rising edge = start/resume
//   Stop    in   1   debounced level, rising edge = pause
//   Zero    in   1   debounced level, rising edge = clear counter
//   Target  in  16   terminal count, 0 = free-running
//   Q       in  16   current counter value (feedback)
//   En      out  1   one-cycle count-enable tick
//   CntClr  out  1   one-cycle active-low synchronous clear to the counter
//   State   out  2   00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
//   Done    out  1   high while in DONE
// -----------------------------------------------------------------------------
module counter_sequencer #(
    parameter int DIV = 50_000_000
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Start,
    input  logic        Stop,
    input  logic        Zero,
    input  logic [15:0] Target,
    input  logic [15:0] Q,
    output logic        En,
    output logic        CntClr,
    output logic [1:0]  State,
    output logic        Done
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          en_q, en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          done_q, done_d;
    logic          start_prev_q, stop_prev_q, zero_prev_q;

    logic start_edge, stop_edge, zero_edge, terminal_hit;

    // Previous-level registers reset to 1 so a button already held at reset
    // release is not mistaken for a fresh press.
    assign start_edge = Start & ~start_prev_q;
    assign stop_edge  = Stop  & ~stop_prev_q;
    assign zero_edge  = Zero  & ~zero_prev_q;

    // Equality only against the live Target: lowering Target below Q means
    // the terminal is met only after the counter wraps round.
    assign terminal_hit = (Target != 16'd0) && (Q == Target);

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        en_d      = 1'b0;
        cnt_clr_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (zero_edge) begin
                    cnt_clr_d = 1'b0;
                end else if (start_edge) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end
            end
            S_RUN: begin
                // Priority Zero > Stop > terminal; a Start edge has no effect here.
                if (zero_edge) begin
                    cnt_clr_d = 1'b0;
                    presc_d   = '0;
                end else if (stop_edge) begin
                    state_d = S_PAUSE;
                end else if (terminal_hit) begin
                    state_d = S_DONE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    en_d    = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                // Prescaler is frozen so a resume completes the interrupted period.
                if (zero_edge) begin
                    cnt_clr_d = 1'b0;
                    presc_d   = '0;
                    state_d   = S_IDLE;
                end else if (start_edge) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (zero_edge) begin
                    cnt_clr_d = 1'b0;
                    presc_d   = '0;
                    state_d   = S_IDLE;
                end
            end
        endcase
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q      <= S_IDLE;
            presc_q      <= '0;
            en_q         <= 1'b0;
            cnt_clr_q    <= 1'b1;
            done_q       <= 1'b0;
            start_prev_q <= 1'b1;
            stop_prev_q  <= 1'b1;
            zero_prev_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            en_q         <= en_d;
            cnt_clr_q    <= cnt_clr_d;
            done_q       <= done_d;
            start_prev_q <= Start;
            stop_prev_q  <= Stop;
            zero_prev_q  <= Zero;
        end
    end

    assign En     = en_q;
    assign CntClr = cnt_clr_q;
    assign State  = state_q;
    assign Done   = done_q;

endmodule
